// File: rtl/axi_write_data_channel_pkg.sv
// Shared types and helpers for the AXI4 write-data channel that follows the
// linear address generator's AW bursts.
package axi_write_data_channel_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StPad,
        StWaitResp
    } wdc_state_e;

    localparam logic [1:0] RespOkay   = 2'd0;
    localparam logic [1:0] RespExokay = 2'd1;
    localparam logic [1:0] RespSlverr = 2'd2;
    localparam logic [1:0] RespDecerr = 2'd3;

    function automatic int unsigned bytes_per_beat(input int unsigned axsize);
        return 32'd1 << axsize;
    endfunction

    function automatic int unsigned beats_per_burst(input int unsigned axlen);
        return axlen + 32'd1;
    endfunction

endpackage

// File: rtl/axi_write_data_channel.sv
// Converts an AXI-Stream into fixed-length AXI4 W bursts, pads the final burst,
// and counts B responses until every burst is acknowledged.
module axi_write_data_channel
    import axi_write_data_channel_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH               = 32,
    parameter int unsigned DATA_WIDTH               = 64,
    parameter int unsigned STRB_WIDTH               = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH                 = 8,
    parameter int unsigned AxLEN_BEATS_PER_TRANSFER = 15,
    parameter int unsigned AxSIZE_BYTES_PER_BEAT    = 3
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic                  start,
    output logic                  done,
    output logic                  error,
    input  logic [ADDR_WIDTH-1:0] dataSizeInBytes,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [STRB_WIDTH-1:0] wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [ID_WIDTH-1:0]   bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int unsigned CntW  = ADDR_WIDTH + 1;
    localparam int unsigned Bpb   = bytes_per_beat(AxSIZE_BYTES_PER_BEAT);
    localparam int unsigned Bpt   = beats_per_burst(AxLEN_BEATS_PER_TRANSFER);
    localparam int unsigned BeatW = (Bpt > 1) ? $clog2(Bpt) : 1;
    localparam int unsigned TailW = (AxSIZE_BYTES_PER_BEAT > 0) ? AxSIZE_BYTES_PER_BEAT : 1;

    localparam logic [CntW-1:0]       BpbRound = CntW'(Bpb - 1);
    localparam logic [CntW-1:0]       BptRound = CntW'(Bpt - 1);
    localparam logic [CntW-1:0]       BptCnt   = CntW'(Bpt);
    localparam logic [ADDR_WIDTH-1:0] BpbSize  = ADDR_WIDTH'(Bpb);
    localparam logic [BeatW-1:0]      LastBeat = BeatW'(AxLEN_BEATS_PER_TRANSFER);

    wdc_state_e        state_q, state_d;
    logic [CntW-1:0]   beats_q, beats_d;   // data beats still to come from the stream
    logic [CntW-1:0]   resp_q, resp_d;     // B responses still outstanding
    logic [BeatW-1:0]  beat_q, beat_d;     // position within the current burst
    logic [TailW-1:0]  tail_q, tail_d;
    logic              error_q, error_d;

    logic [CntW-1:0]       total_beats;
    logic [CntW-1:0]       total_bursts;
    logic [TailW-1:0]      size_tail;
    logic [STRB_WIDTH-1:0] tail_mask;
    logic                  final_beat;
    logic                  burst_end;
    logic                  b_hs;
    logic                  unused_bid;

    assign unused_bid = ^bid;

    assign total_beats  = ({1'b0, dataSizeInBytes} + BpbRound) >> AxSIZE_BYTES_PER_BEAT;
    assign total_bursts = (total_beats + BptRound) / BptCnt;
    assign size_tail    = TailW'(dataSizeInBytes % BpbSize);

    assign final_beat = (beats_q == CntW'(1));
    assign burst_end  = (beat_q == LastBeat);

    assign done  = (state_q == StIdle);
    assign error = error_q;

    always_comb begin
        tail_mask = ~({STRB_WIDTH{1'b1}} << tail_q);
    end

    always_comb begin
        state_d       = state_q;
        beats_d       = beats_q;
        resp_d        = resp_q;
        beat_d        = beat_q;
        tail_d        = tail_q;
        error_d       = error_q;
        wvalid        = 1'b0;
        wlast         = 1'b0;
        wdata         = '0;
        wstrb         = '0;
        s_axis_tready = 1'b0;
        bready        = (state_q != StIdle);

        // Responses are accepted in every active state, even ahead of the W beats.
        b_hs = bvalid && bready;
        if (b_hs && (resp_q != '0)) begin
            resp_d = resp_q - CntW'(1);
        end
        if (b_hs && (bresp != RespOkay)) begin
            error_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start && (dataSizeInBytes != '0)) begin
                    state_d = StData;
                    beats_d = total_beats;
                    resp_d  = total_bursts;
                    beat_d  = '0;
                    tail_d  = size_tail;
                    error_d = 1'b0;
                end
            end

            StData: begin
                wvalid        = s_axis_tvalid;
                s_axis_tready = wready;
                wdata         = s_axis_tdata;
                wlast         = burst_end;
                wstrb         = (final_beat && (tail_q != '0)) ? tail_mask : '1;
                if (s_axis_tvalid && wready) begin
                    beats_d = beats_q - CntW'(1);
                    beat_d  = burst_end ? '0 : beat_q + BeatW'(1);
                    if (final_beat) begin
                        state_d = burst_end ? StWaitResp : StPad;
                    end
                end
            end

            StPad: begin
                wvalid = 1'b1;
                wlast  = burst_end;
                if (wready) begin
                    beat_d = burst_end ? '0 : beat_q + BeatW'(1);
                    if (burst_end) begin
                        state_d = StWaitResp;
                    end
                end
            end

            StWaitResp: begin
                if (resp_d == '0) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q <= StIdle;
            beats_q <= '0;
            resp_q  <= '0;
            beat_q  <= '0;
            tail_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
            resp_q  <= resp_d;
            beat_q  <= beat_d;
            tail_q  <= tail_d;
            error_q <= error_d;
        end
    end

endmodule

// File: doc/axi_write_data_channel.md
Name: axi_write_data_channel

Overview:
- Write-data companion to the linear address generator: turns an AXI-Stream of pixel/framebuffer data into AXI4 W-channel bursts matching the AW bursts the generator issues, then collects the B responses.
- Started with the same start/dataSizeInBytes pair as the address generator. Sits between the framebuffer stream source and the AXI interconnect.
- Raises done once every burst has been written and acknowledged.

Parameters:
- ADDR_WIDTH, 32, width of dataSizeInBytes.
- DATA_WIDTH, 64, stream and W data width; must equal 8 * 2**AxSIZE_BYTES_PER_BEAT.
- STRB_WIDTH, DATA_WIDTH/8, wstrb width.
- ID_WIDTH, 8, width of bid (ignored, accepted for interface completeness).
- AxLEN_BEATS_PER_TRANSFER, 15, beats per burst minus one; must match the address generator.
- AxSIZE_BYTES_PER_BEAT, 3, log2 bytes per beat.

Ports:
- aclk  in  1  clock
- resetn  in  1  synchronous active-low reset
- start  in  1  begin transfer; sampled only while done=1
- done  out  1  idle / transfer complete
- error  out  1  a non-OKAY bresp occurred in the last transfer
- dataSizeInBytes  in  ADDR_WIDTH  bytes to write; sampled with start
- s_axis_tvalid  in  1  stream beat valid
- s_axis_tready  out  1  stream beat accepted
- s_axis_tdata  in  DATA_WIDTH  stream data
- wdata  out  DATA_WIDTH  W data
- wstrb  out  STRB_WIDTH  W byte strobes
- wlast  out  1  last beat of burst
- wvalid  out  1  W valid
- wready  in  1  W ready
- bid  in  ID_WIDTH  response ID, ignored
- bresp  in  2  write response
- bvalid  in  1  response valid
- bready  out  1  response ready

Behaviour:
- Reset values: done=1, error=0, wvalid=0, wlast=0, wstrb=0, wdata=0, s_axis_tready=0, bready=0, state=IDLE, all counters 0. Reset mid-transfer aborts immediately; no partial burst completion.
- Derived values, computed at start in ADDR_WIDTH+1 bits:
  - totalBeats = ceil(size / BPB), where BPB = 2**AxSIZE_BYTES_PER_BEAT.
  - totalBursts = ceil(totalBeats / BPT), where BPT = AxLEN_BEATS_PER_TRANSFER+1.
  - tailBytes = size mod BPB.
- States:
  - IDLE: done=1. On start && size!=0, the next cycle has done=0, error=0, bready=1, counters loaded, state=DATA. start && size==0 leaves done=1 and generates no beats. start while done=0 is ignored.
  - DATA: combinational pass-through with zero latency: wvalid=s_axis_tvalid, s_axis_tready=wready, wdata=s_axis_tdata.
    - wstrb is all ones, except on the final data beat when tailBytes!=0; then only the low tailBytes bits are set.
    - A beat transfers on wvalid&&wready. beatInBurst counts 0..AxLEN; wlast=1 when beatInBurst==AxLEN.
    - After the final data beat: if it was also the burst's last beat, go to WAIT_RESP; otherwise go to PAD.
  - PAD: s_axis_tready=0, wvalid=1, wdata=0, wstrb=0. Pads the final burst to BPT beats; wlast on the final pad beat, then WAIT_RESP.
  - WAIT_RESP: wvalid=0. When respRemaining==0, done=1, bready=0, state=IDLE.
- Response handling, concurrent with DATA/PAD/WAIT_RESP:
  - bready=1 in all non-IDLE states.
  - Each bvalid&&bready decrements respRemaining, which is loaded with totalBursts. Responses may arrive before all W beats are sent.
  - bresp!=0 sets the sticky error flag; it is cleared only by the next accepted start.
- wvalid, once asserted in PAD, stays high until handshake (AXI rule). In DATA, wvalid follows tvalid, so stream-side AXIS rules carry over.
- A response arriving in the same cycle as the last W beat is counted normally.
- The stream supplies exactly totalBeats beats. Extra beats are not consumed (tready=0 outside DATA).

Decomposition:
- Shared package: BPB/BPT localparam derivation, AXI response codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), and the state encoding (IDLE, DATA, PAD, WAIT_RESP).
- No sub-module needed. Optionally, a tiny wstrb_tail_mask function in the package maps tailBytes to a strobe mask.

Test Plan (DATA_WIDTH=64, AxLEN=15, i.e. 128 B/burst):
- size=256, wready=1, tvalid always 1 -> 32 beats, wlast on beats 16 and 32, wstrb=0xFF throughout; two OKAY responses; done=1 the cycle after the 2nd B handshake.
- size=100 -> 13 data beats, beat 13 wstrb=0x0F; beats 14-16 have wdata=0, wstrb=0x00, s_axis_tready=0; wlast on beat 16; 1 response -> done.
- size=256 with wready toggling 1/0 and tvalid gaps -> no beat duplicated or lost, order preserved, wlast positions unchanged, wvalid held during PAD stalls.
- size=384, bresp=2 on the 2nd response -> error=1 at completion; next start clears error to 0.
- start pulsed mid-transfer with a different size -> ignored; start with size=0 -> done stays 1, no W activity; B response arriving before the last W beat is counted.
- resetn=0 asserted at beat 5 of 16 -> the next cycle has done=1, wvalid=0, bready=0; a fresh start with size=128 completes normally.
